// File: rtl/l2_defs.sv
// Shared definitions for the L2-to-DRAM controller: opcodes, request field
// offsets and FSM state encodings.
package l2_defs;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_PWB = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Request word layout: {tag[37:34], op[33:32], addr[31:0]}
    localparam int REQ_ADDR_LSB = 0;
    localparam int REQ_OP_LSB   = 32;
    localparam int REQ_TAG_LSB  = 34;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/dram_mem_array.sv
// Single-port synchronous DRAM model with registered read data.
// Contents are never reset; a read in a write cycle returns the old word.
module dram_mem_array #(
    parameter int DEPTH_BIT  = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_BIT-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_BIT)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/l2_dram_ctrl.sv
// Serialized consumer of the L2 request queue: pops one request, performs it
// against the DRAM model after a fixed latency, and holds the response until L2 takes it.
module l2_dram_ctrl
    import l2_defs::*;
#(
    parameter int REQUEST_SIZE  = 38,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH_BIT = 10,
    parameter int RD_LATENCY    = 4,
    parameter int WR_LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    q_empty,
    output logic                    q_pop_en,
    input  logic                    q_valid,
    input  logic [REQUEST_SIZE-1:0] q_req,
    input  logic [DATA_WIDTH-1:0]   q_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [1:0]              resp_op,
    output logic [3:0]              resp_tag,
    output logic [ADDR_WIDTH-1:0]   resp_addr,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t                  state, state_n;
    logic [REQUEST_SIZE-1:0] req_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]        cnt;
    logic                    rd_sel;
    logic                    err_q;
    logic [1:0]              req_op;
    logic [1:0]              q_op;
    logic                    access_done;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    assign req_op      = req_q[REQ_OP_LSB +: 2];
    assign q_op        = q_req[REQ_OP_LSB +: 2];
    assign access_done = (state == ST_ACCESS) && (cnt == '0);
    assign mem_we      = access_done && ((req_op == OP_WR) || (req_op == OP_PWB));

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (!q_empty)   state_n = ST_POP;
            ST_POP:    state_n = q_valid ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: if (cnt == '0)  state_n = ST_RESP;
            ST_RESP:   if (resp_ready) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            req_q  <= '0;
            data_q <= '0;
            cnt    <= '0;
            rd_sel <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_POP && q_valid) begin
                req_q  <= q_req;
                data_q <= q_data;
                case (q_op)
                    OP_RD:         cnt <= CNT_W'(RD_LATENCY - 1);
                    OP_WR, OP_PWB: cnt <= CNT_W'(WR_LATENCY - 1);
                    default:       cnt <= '0;
                endcase
            end else if (state == ST_ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access_done) begin
                rd_sel <= (req_op == OP_RD);
                err_q  <= (req_op == OP_ILL);
            end
        end
    end

    // The RAM is addressed from the latched request, so its registered read
    // word stays stable for the whole response hold.
    dram_mem_array #(
        .DEPTH_BIT  (MEM_DEPTH_BIT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (req_q[MEM_DEPTH_BIT+1:2]),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

    // Gated by reset so no pop escapes while the FSM is held in IDLE.
    assign q_pop_en   = rst && (state == ST_IDLE) && !q_empty;
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_op    = req_op;
    assign resp_tag   = req_q[REQ_TAG_LSB +: 4];
    assign resp_addr  = req_q[REQ_ADDR_LSB +: ADDR_WIDTH];
    assign resp_err   = err_q;
    assign resp_data  = rd_sel ? mem_rdata : data_q;

endmodule

// File: tb/tb_l2_dram_ctrl.sv
// Directed bench for l2_dram_ctrl: reset, write/read, retry, backpressure,
// aliasing, illegal op and reset during access.
module tb_l2_dram_ctrl;

    logic        clk;
    logic        rst;
    logic        q_empty;
    logic        q_pop_en;
    logic        q_valid;
    logic [37:0] q_req;
    logic [31:0] q_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_op;
    logic [3:0]  resp_tag;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    int ncmp = 0;
    int nerr = 0;

    l2_dram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .q_empty    (q_empty),
        .q_pop_en   (q_pop_en),
        .q_valid    (q_valid),
        .q_req      (q_req),
        .q_data     (q_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_op    (resp_op),
        .resp_tag   (resp_tag),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // One full request: pop, present entry, measure latency, check response,
    // optionally hold resp_ready low for 'hold' cycles, then accept.
    task automatic do_req(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] tag,
                          input int lat, input logic chk_data,
                          input logic [31:0] exp_data, input int hold);
        int n;
        @(negedge clk); q_empty = 1'b0; #1;
        chk("pop_en_idle", 64'(q_pop_en), 64'(1));
        @(negedge clk); q_empty = 1'b1; q_valid = 1'b1; q_req = {tag, op, addr}; q_data = data; #1;
        chk("pop_en_in_pop", 64'(q_pop_en), 64'(0));
        chk("busy_in_pop", 64'(busy), 64'(1));
        @(negedge clk); q_valid = 1'b0; q_req = '0; q_data = '0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_latency", 64'(n), 64'(lat));
        if (n >= 20) return;
        chk("resp_op", 64'(resp_op), 64'(op));
        chk("resp_tag", 64'(resp_tag), 64'(tag));
        chk("resp_addr", 64'(resp_addr), 64'(addr));
        chk("resp_err", 64'(resp_err), 64'(op == 2'b11));
        if (chk_data) chk("resp_data", 64'(resp_data), 64'(exp_data));
        if (hold > 0) q_empty = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); #1;
            chk("hold_valid", 64'(resp_valid), 64'(1));
            chk("hold_tag", 64'(resp_tag), 64'(tag));
            chk("hold_addr", 64'(resp_addr), 64'(addr));
            if (chk_data) chk("hold_data", 64'(resp_data), 64'(exp_data));
            chk("hold_no_pop", 64'(q_pop_en), 64'(0));
            chk("hold_busy", 64'(busy), 64'(1));
        end
        resp_ready = 1'b1;
        @(negedge clk); resp_ready = 1'b0; q_empty = 1'b1; #1;
        chk("post_resp_valid", 64'(resp_valid), 64'(0));
        chk("post_resp_idle", 64'(busy), 64'(0));
    endtask

    // Pop whose entry is not ready: FSM must fall back to IDLE and re-pop.
    task automatic pop_no_valid();
        @(negedge clk); q_empty = 1'b0; q_valid = 1'b0; #1;
        chk("retry_pop_en", 64'(q_pop_en), 64'(1));
        @(negedge clk); #1;
        chk("retry_in_pop", 64'(busy), 64'(1));
        chk("retry_pop_low", 64'(q_pop_en), 64'(0));
        @(negedge clk); #1;
        chk("retry_back_idle", 64'(busy), 64'(0));
        chk("retry_repop", 64'(q_pop_en), 64'(1));
        q_empty = 1'b1;
    endtask

    initial begin
        rst = 1'b0; q_empty = 1'b0; q_valid = 1'b0; q_req = '0; q_data = '0; resp_ready = 1'b0;

        // Reset held with a non-empty queue
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_pop_en", 64'(q_pop_en), 64'(0));
            chk("rst_resp_valid", 64'(resp_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
        end
        chk("rst_resp_op", 64'(resp_op), 64'(0));
        chk("rst_resp_tag", 64'(resp_tag), 64'(0));
        chk("rst_resp_addr", 64'(resp_addr), 64'(0));
        chk("rst_resp_data", 64'(resp_data), 64'(0));
        chk("rst_resp_err", 64'(resp_err), 64'(0));
        @(negedge clk); rst = 1'b1; #1;
        chk("rel_pop_en", 64'(q_pop_en), 64'(1));
        q_empty = 1'b1;

        // Seed 0x20, then write/read 0x10
        do_req(2'b01, 32'h0000_0020, 32'hCAFE_0020, 4'd1, 2, 1'b1, 32'hCAFE_0020, 0);
        do_req(2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 4'd3, 2, 1'b1, 32'hDEAD_BEEF, 0);
        do_req(2'b00, 32'h0000_0010, 32'h0,         4'd4, 4, 1'b1, 32'hDEAD_BEEF, 0);

        // Two withheld entries, then a normal read
        pop_no_valid();
        pop_no_valid();
        do_req(2'b00, 32'h0000_0020, 32'h0, 4'd2, 4, 1'b1, 32'hCAFE_0020, 0);

        // Backpressure on a write response
        do_req(2'b01, 32'h0000_0030, 32'h3333_0030, 4'd5, 2, 1'b1, 32'h3333_0030, 5);

        // PWB behaves as a write
        do_req(2'b10, 32'h0000_0040, 32'h4444_0040, 4'd10, 2, 1'b1, 32'h4444_0040, 0);
        do_req(2'b00, 32'h0000_0040, 32'h0,         4'd11, 4, 1'b1, 32'h4444_0040, 0);

        // Aliasing: 0x1004 and 0x0004 share a word; low bits ignored too
        do_req(2'b01, 32'h0000_1004, 32'hA1A5_1004, 4'd6, 2, 1'b1, 32'hA1A5_1004, 0);
        do_req(2'b00, 32'h0000_0004, 32'h0,         4'd7, 4, 1'b1, 32'hA1A5_1004, 0);
        do_req(2'b00, 32'h0000_0007, 32'h0,         4'd12, 4, 1'b1, 32'hA1A5_1004, 2);

        // Illegal op: error flagged, memory untouched
        do_req(2'b11, 32'h0000_0010, 32'hBAD0_BAD0, 4'd8, 1, 1'b0, 32'h0, 0);
        do_req(2'b00, 32'h0000_0010, 32'h0,         4'd9, 4, 1'b1, 32'hDEAD_BEEF, 0);

        // Reset during ACCESS of a write to 0x20
        @(negedge clk); q_empty = 1'b0; #1;
        chk("abort_pop_en", 64'(q_pop_en), 64'(1));
        @(negedge clk); q_empty = 1'b1; q_valid = 1'b1; q_req = {4'd9, 2'b01, 32'h0000_0020}; q_data = 32'h5555_5555;
        @(negedge clk); q_valid = 1'b0; q_req = '0; q_data = '0; #1;
        chk("abort_busy_access", 64'(busy), 64'(1));
        rst = 1'b0; #1;
        chk("abort_busy_rst", 64'(busy), 64'(0));
        chk("abort_valid_rst", 64'(resp_valid), 64'(0));
        repeat (2) begin
            @(negedge clk); #1;
            chk("abort_no_resp", 64'(resp_valid), 64'(0));
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("abort_post_valid", 64'(resp_valid), 64'(0));
            chk("abort_post_busy", 64'(busy), 64'(0));
        end
        do_req(2'b00, 32'h0000_0020, 32'h0, 4'd13, 4, 1'b1, 32'hCAFE_0020, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
